// File: rtl/mips_div_unit_pkg.sv
// Shared definitions for the execute-stage iterative divider.
package mips_div_unit_pkg;

  // Default operand/result width for the MIPS datapath.
  localparam int DIV_WIDTH = 32;

  // Divider sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } divState_e;

  // Divide-by-zero quotient is all ones; replicated to WIDTH at the use site.
  localparam logic DIV_ZERO_QUOT_BIT = 1'b1;

endpackage

// File: rtl/mips_div_unit_if.sv
// Handshake/data bundle between EX/hazard logic (master) and the divider (slave).
interface mips_div_unit_if
  import mips_div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) ();

  logic             Start;
  logic             Signed;
  logic             Annul;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             Busy;
  logic             Ready;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;

  modport master (
    output Start, Signed, Annul, SrcA, SrcB,
    input  Busy, Ready, Quotient, Remainder
  );

  modport slave (
    input  Start, Signed, Annul, SrcA, SrcB,
    output Busy, Ready, Quotient, Remainder
  );

endinterface

// File: rtl/mips_div_unit_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor, keep the difference when it does not go negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] partRem,
  input  logic             dividendMsb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] nextRem,
  output logic             quotBit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  // The shifted remainder can use bit WIDTH, so the WIDTH+1-bit subtract
  // carries an explicit borrow bit above it to decide the sign.
  assign shifted = {partRem, dividendMsb};
  assign trial   = {1'b0, shifted} - {2'b00, divisor};

  // A non-negative difference is always below the divisor, so bit WIDTH is
  // zero exactly when no borrow occurred.
  assign quotBit = ~|trial[WIDTH+1:WIDTH];
  assign nextRem = quotBit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/mips_div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: magnitude division over WIDTH
// cycles, sign fixup on the way into DONE, stall request while BUSY.
module mips_div_unit
  import mips_div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  mips_div_unit_if.slave  div
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  divState_e        state;
  logic [CW-1:0]    iterCnt;
  logic [WIDTH-1:0] partRem;
  logic [WIDTH-1:0] dividend;   // shifts out dividend bits, shifts in quotient bits
  logic [WIDTH-1:0] divisor;
  logic             quotNeg;
  logic             remNeg;
  logic [WIDTH-1:0] quotReg;
  logic [WIDTH-1:0] remReg;

  logic [WIDTH-1:0] stepRem;
  logic             stepQBit;
  logic [WIDTH-1:0] rawQuot;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic             lastIter;

  // Magnitudes are only taken for DIV; DIVU passes operands through.
  assign absA     = (div.Signed && div.SrcA[WIDTH-1]) ? -div.SrcA : div.SrcA;
  assign absB     = (div.Signed && div.SrcB[WIDTH-1]) ? -div.SrcB : div.SrcB;
  assign lastIter = (iterCnt == CW'(WIDTH - 1));
  assign rawQuot  = {dividend[WIDTH-2:0], stepQBit};

  div_step #(.WIDTH(WIDTH)) uStep (
    .partRem     (partRem),
    .dividendMsb (dividend[WIDTH-1]),
    .divisor     (divisor),
    .nextRem     (stepRem),
    .quotBit     (stepQBit)
  );

  // Sequencing, iteration datapath and registered results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      iterCnt  <= '0;
      partRem  <= '0;
      dividend <= '0;
      divisor  <= '0;
      quotNeg  <= 1'b0;
      remNeg   <= 1'b0;
      quotReg  <= '0;
      remReg   <= '0;
    end else if (div.Annul) begin
      // Flush abandons the operation; results keep their previous values.
      state <= IDLE;
    end else begin
      case (state)
        BUSY: begin
          partRem  <= stepRem;
          dividend <= rawQuot;
          iterCnt  <= iterCnt + CW'(1);
          if (lastIter) begin
            state   <= DONE;
            quotReg <= quotNeg ? -rawQuot : rawQuot;
            remReg  <= remNeg  ? -stepRem : stepRem;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request, so back-to-back
          // operations see no idle bubble.
          if (div.Start) begin
            if (div.SrcB == '0) begin
              state   <= DONE;
              quotReg <= {WIDTH{DIV_ZERO_QUOT_BIT}};
              remReg  <= div.SrcA;
            end else begin
              state    <= BUSY;
              dividend <= absA;
              divisor  <= absB;
              partRem  <= '0;
              iterCnt  <= '0;
              quotNeg  <= div.Signed & (div.SrcA[WIDTH-1] ^ div.SrcB[WIDTH-1]);
              remNeg   <= div.Signed & div.SrcA[WIDTH-1];
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign div.Busy      = (state == BUSY);
  assign div.Ready     = (state == DONE);
  assign div.Quotient  = quotReg;
  assign div.Remainder = remReg;

endmodule

// File: doc/mips_div_unit.md
# mips_div_unit

Iterative multi-cycle divider for the MIPS pipeline's execute stage. It takes the operands and the DIV/DIVU decision produced for EX, runs a radix-2 restoring division over WIDTH cycles, and hands quotient/remainder to the HI/LO write path. While a division is in flight it raises a stall request to the hazard logic.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 2.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- Start  in  1  request a division this cycle (EX holds a DIV/DIVU).
- Signed  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with Start.
- Annul  in  1  abandon the current division (EX flush).
- SrcA  in  WIDTH  dividend; sampled with Start.
- SrcB  in  WIDTH  divisor; sampled with Start.
- Busy  out  1  division in progress; stall request to the hazard unit.
- Ready  out  1  one-cycle pulse: Quotient/Remainder are valid this cycle.
- Quotient  out  WIDTH  LO value.
- Remainder  out  WIDTH  HI value.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - Start=1 and SrcB≠0: latch |SrcA| and |SrcB| (absolute values only when Signed=1), the sign of the quotient (SrcA[MSB]^SrcB[MSB]) and the sign of the remainder (SrcA[MSB]). Clear the partial remainder and the iteration counter, then go to BUSY.
  - Start=1 and SrcB=0: go to DONE with Quotient = all ones and Remainder = SrcA (raw, unmodified). The divide-by-zero result is fixed by this block.
- BUSY, each cycle:
  - Shift {partial remainder, dividend} left by one bit.
  - Trial-subtract the divisor using a WIDTH+1-bit subtract. If the result is non-negative, keep it and shift in quotient bit 1; otherwise shift in 0.
  - The counter counts 0..WIDTH-1. On the last iteration go to DONE.
- On entry to DONE:
  - Quotient is negated if the quotient sign bit is set.
  - Remainder is negated if the remainder sign bit is set.
  - Both are registered.
- DONE lasts one cycle with Ready=1.
  - Start=1 in DONE begins a new division, with the same rules as IDLE.
  - Otherwise go to IDLE.
- Quotient/Remainder hold their last values until the next DONE.
- Signed overflow, 0x80000000 / -1: Quotient = 0x80000000, Remainder = 0. This falls out of the unsigned magnitude path and needs no special case.
- Start in BUSY is ignored.
- Annul (any state) forces IDLE at the next edge:
  - Ready is not asserted.
  - Quotient/Remainder are unchanged.
  - Annul has priority over Start in the same cycle.
- rst (any time):
  - State = IDLE; Busy = 0; Ready = 0.
  - Quotient = 0; Remainder = 0; all internal registers = 0.

## Timing
- Busy = (state==BUSY). It is registered-state-derived with no combinational path from Start. The hazard unit stalls EX on Start|Busy.
- Normal latency:
  - Start sampled at edge E0.
  - BUSY during cycles E0..E0+WIDTH-1.
  - DONE/Ready in the cycle after edge E0+WIDTH, i.e. Ready is high WIDTH+1 cycles after Start was presented.
- Divide-by-zero latency: Ready in the cycle after edge E0 (one cycle).
- Back-to-back: Start during Ready cycle → Busy in the very next cycle; no idle bubble.
- Ready is never high on two consecutive cycles except for back-to-back divide-by-zero operations.

## Structure
- Shared package:
  - State encoding (IDLE/BUSY/DONE).
  - Default WIDTH.
  - The divide-by-zero quotient constant (all ones).
- One natural sub-module: div_step.
  - Purely combinational, one restoring iteration.
  - Inputs: partial remainder, dividend MSB, divisor.
  - Outputs: next partial remainder, quotient bit.
- Top level holds the FSM, counter, operand/sign registers and the final sign fixup.

## Test plan
- DIVU 100/7 → Ready exactly 33 cycles after Start cycle; Quotient=14, Remainder=2; Busy high for 32 cycles.
- DIV -7/2 (0xFFFFFFF9 / 2) → Quotient=0xFFFFFFFD (-3), Remainder=0xFFFFFFFF (-1). DIV 7/-2 → Quotient=0xFFFFFFFD, Remainder=1.
- DIV 0x80000000 / 0xFFFFFFFF → Quotient=0x80000000, Remainder=0. DIVU 5/0 → Ready one cycle after Start, Quotient=0xFFFFFFFF, Remainder=5, Busy never asserted.
- Annul at BUSY cycle 10 → Busy low next cycle, no Ready, outputs keep prior results. A new DIVU 9/3 issued right after → Quotient=3, Remainder=0 on schedule.
- Back-to-back: Start asserted in Ready cycle of 100/7 with 50/6 → second Ready 33 cycles later, Quotient=8, Remainder=2. Start pulses during BUSY → ignored, result unaffected.
- rst asserted asynchronously mid-BUSY (between edges) → Busy/Ready/Quotient/Remainder all 0 immediately. After release, a fresh DIVU 1/1 gives Quotient=1, Remainder=0.
